// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared encodings and constants for the two-master Wishbone arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

  // One-hot grant vector for a given owner index
  function automatic logic [1:0] onehot_grant(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// rtl/wb_arb_timer.sv - per-transaction timeout counter with clear/enable and expire pulse
module wb_arb_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

  logic [W-1:0] tmr_q, tmr_d;

  // Clear has priority over counting; count only while the transaction is on the bus
  always_comb begin
    tmr_d = tmr_q;
    if (clr_i) begin
      tmr_d = '0;
    end else if (en_i) begin
      tmr_d = tmr_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  // The FSM leaves BUSY on expiry, so this is high for exactly one cycle
  assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (tmr_q == LAST);

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin two-master arbiter with ACK capture and slave timeout
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_STB,
  input  logic        m0_WE,
  input  logic [31:0] m0_ADDR,
  input  logic [31:0] m0_DAT_I,
  output logic [31:0] m0_DAT_O,
  output logic        m0_ACK,
  output logic        m0_ERR,
  input  logic        m1_STB,
  input  logic        m1_WE,
  input  logic [31:0] m1_ADDR,
  input  logic [31:0] m1_DAT_I,
  output logic [31:0] m1_DAT_O,
  output logic        m1_ACK,
  output logic        m1_ERR,
  output logic        bus_STB,
  output logic        bus_WE,
  output logic [31:0] bus_ADDR,
  output logic [31:0] bus_DAT_O,
  input  logic [31:0] bus_DAT_I,
  input  logic        bus_ACK,
  output logic [1:0]  grant,
  output logic [7:0]  timeout_cnt
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] cap_data_q, cap_data_d;
  logic        cap_err_q, cap_err_d;
  logic [7:0]  timeout_cnt_q, timeout_cnt_d;
  logic        tmr_clr, tmr_en, tmr_expire;
  logic        owner_stb;

  assign owner_stb   = owner_q ? m1_STB : m0_STB;
  assign timeout_cnt = timeout_cnt_q;

  wb_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  // State and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= MASTER_CPU;
      last_grant_q  <= MASTER_DMA;
      cap_data_q    <= '0;
      cap_err_q     <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cap_data_q    <= cap_data_d;
      cap_err_q     <= cap_err_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  // Next-state and outputs; master ACKs depend only on registers, never on bus_ACK
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cap_data_d    = cap_data_q;
    cap_err_d     = cap_err_q;
    timeout_cnt_d = timeout_cnt_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;
    bus_STB       = 1'b0;
    bus_WE        = 1'b0;
    bus_ADDR      = '0;
    bus_DAT_O     = '0;
    grant         = 2'b00;
    m0_ACK        = 1'b0;
    m0_ERR        = 1'b0;
    m0_DAT_O      = '0;
    m1_ACK        = 1'b0;
    m1_ERR        = 1'b0;
    m1_DAT_O      = '0;

    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (m0_STB || m1_STB) begin
          state_d = ST_BUSY;
          if (m0_STB && m1_STB) begin
            owner_d = ~last_grant_q;
          end else begin
            owner_d = m1_STB ? MASTER_DMA : MASTER_CPU;
          end
        end
      end

      ST_BUSY: begin
        tmr_en    = 1'b1;
        bus_STB   = 1'b1;
        bus_WE    = owner_q ? m1_WE : m0_WE;
        bus_ADDR  = owner_q ? m1_ADDR : m0_ADDR;
        bus_DAT_O = owner_q ? m1_DAT_I : m0_DAT_I;
        grant     = onehot_grant(owner_q);
        if (bus_ACK) begin
          cap_data_d   = bus_DAT_I;
          cap_err_d    = 1'b0;
          last_grant_d = owner_q;
          state_d      = ST_RELEASE;
        end else if (!owner_stb) begin
          // Abort: the owner gave up; no completion and fairness untouched
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          cap_data_d   = ERR_DATA;
          cap_err_d    = 1'b1;
          last_grant_d = owner_q;
          if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // Hold the completion until the owner drops STB so slow masters see it once
        grant = onehot_grant(owner_q);
        if (owner_q) begin
          m1_ACK   = 1'b1;
          m1_ERR   = cap_err_q;
          m1_DAT_O = cap_data_q;
        end else begin
          m0_ACK   = 1'b1;
          m0_ERR   = cap_err_q;
          m0_DAT_O = cap_data_q;
        end
        if (!owner_stb) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

  localparam int          TMO     = 16;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_STB, m0_WE, m1_STB, m1_WE;
  logic [31:0] m0_ADDR, m0_DAT_I, m1_ADDR, m1_DAT_I;
  logic [31:0] m0_DAT_O, m1_DAT_O;
  logic        m0_ACK, m0_ERR, m1_ACK, m1_ERR;
  logic        bus_STB, bus_WE, bus_ACK;
  logic [31:0] bus_ADDR, bus_DAT_O, bus_DAT_I;
  logic [1:0]  grant;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int errors = 0;

  wb_bus_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA      (ERR_VAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_STB     (m0_STB),
    .m0_WE      (m0_WE),
    .m0_ADDR    (m0_ADDR),
    .m0_DAT_I   (m0_DAT_I),
    .m0_DAT_O   (m0_DAT_O),
    .m0_ACK     (m0_ACK),
    .m0_ERR     (m0_ERR),
    .m1_STB     (m1_STB),
    .m1_WE      (m1_WE),
    .m1_ADDR    (m1_ADDR),
    .m1_DAT_I   (m1_DAT_I),
    .m1_DAT_O   (m1_DAT_O),
    .m1_ACK     (m1_ACK),
    .m1_ERR     (m1_ERR),
    .bus_STB    (bus_STB),
    .bus_WE     (bus_WE),
    .bus_ADDR   (bus_ADDR),
    .bus_DAT_O  (bus_DAT_O),
    .bus_DAT_I  (bus_DAT_I),
    .bus_ACK    (bus_ACK),
    .grant      (grant),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s0;
    logic       s1;
    logic       ack;
    logic [1:0] grant;
    logic       bstb;
    logic       a0;
    logic       a1;
  } vec_t;

  vec_t tbl[13];

  // Reference model state (transaction-level view of the arbiter)
  bit          md_on_bus, md_hold;
  int          md_who, md_last, md_age, md_tocnt;
  logic [31:0] md_data;
  logic        md_err;

  logic        req[2];
  logic        we_r[2];
  logic [31:0] ad[2], dt[2];
  logic [143:0] exp_v;

  function automatic logic [143:0] snap();
    return {bus_STB, bus_WE, bus_ADDR, bus_DAT_O, grant,
            m0_ACK, m0_ERR, m0_DAT_O, m1_ACK, m1_ERR, m1_DAT_O, timeout_cnt};
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_STB = 1'b0; m0_WE = 1'b0; m0_ADDR = '0; m0_DAT_I = '0;
    m1_STB = 1'b0; m1_WE = 1'b0; m1_ADDR = '0; m1_DAT_I = '0;
    bus_ACK = 1'b0; bus_DAT_I = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    md_on_bus = 0; md_hold = 0; md_who = 0; md_last = 1; md_age = 0;
    md_tocnt = 0; md_data = '0; md_err = 1'b0;
  endtask

  // Expected outputs for the current cycle from the model and applied inputs
  function automatic logic [143:0] model_expect();
    logic        e_ack0, e_ack1;
    logic [1:0]  e_grant;
    e_grant = (md_on_bus || md_hold) ? ((md_who == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_ack0  = md_hold && (md_who == 0);
    e_ack1  = md_hold && (md_who == 1);
    return {md_on_bus ? 1'b1 : 1'b0,
            md_on_bus ? we_r[md_who] : 1'b0,
            md_on_bus ? ad[md_who] : 32'h0,
            md_on_bus ? dt[md_who] : 32'h0,
            e_grant,
            e_ack0, e_ack0 ? md_err : 1'b0, e_ack0 ? md_data : 32'h0,
            e_ack1, e_ack1 ? md_err : 1'b0, e_ack1 ? md_data : 32'h0,
            8'(md_tocnt)};
  endfunction

  // Advance the model across one clock edge
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (md_on_bus) begin
      if (bus_ACK) begin
        md_data = bus_DAT_I; md_err = 1'b0; md_last = md_who;
        md_on_bus = 0; md_hold = 1;
      end else if (!req[md_who]) begin
        md_on_bus = 0;
      end else if (md_age == TMO - 1) begin
        md_data = ERR_VAL; md_err = 1'b1; md_last = md_who;
        md_tocnt = (md_tocnt < 255) ? md_tocnt + 1 : 255;
        md_on_bus = 0; md_hold = 1;
      end else begin
        md_age++;
      end
    end else if (md_hold) begin
      if (!req[md_who]) md_hold = 0;
    end else if (req[0] || req[1]) begin
      md_who    = (req[0] && req[1]) ? 1 - md_last : (req[1] ? 1 : 0);
      md_on_bus = 1;
      md_age    = 0;
    end
  endtask

  initial begin
    // Tie / fairness table: {m0_STB, m1_STB, bus_ACK, grant, bus_STB, m0_ACK, m1_ACK}
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #2;
    chk("reset_state", snap(), 144'h0);

    // Round-robin ties straight after reset
    for (int i = 0; i < 13; i++) begin
      m0_STB = tbl[i].s0; m1_STB = tbl[i].s1; bus_ACK = tbl[i].ack;
      bus_DAT_I = 32'(i);
      #2;
      chk($sformatf("tie_row%0d", i), {139'h0, grant, bus_STB, m0_ACK, m1_ACK},
          {139'h0, tbl[i].grant, tbl[i].bstb, tbl[i].a0, tbl[i].a1});
      next_cycle();
    end

    // m0 read, slave ACKs two cycles after bus_STB
    do_reset();
    m0_STB = 1'b1; m0_ADDR = 32'h0000_0010;
    #2;
    chk("rd_idle_stb", {143'h0, bus_STB}, 144'h0);
    next_cycle();
    #2;
    chk("rd_busy", {141'h0, bus_STB, grant}, {141'h0, 1'b1, 2'b01});
    next_cycle();
    next_cycle();
    bus_ACK = 1'b1; bus_DAT_I = 32'h1234_5678;
    #2;
    chk("rd_no_comb_ack", {143'h0, m0_ACK}, 144'h0);
    next_cycle();
    bus_ACK = 1'b0; bus_DAT_I = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("rd_release%0d", i), {109'h0, m0_ACK, m0_ERR, m0_DAT_O, bus_STB, m1_ACK},
          {109'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0});
      next_cycle();
    end
    m0_STB = 1'b0;
    next_cycle();
    #2;
    chk("rd_done", {111'h0, m0_ACK, m0_DAT_O}, 144'h0);

    // m1 write while m0 inputs toggle
    m1_STB = 1'b1; m1_WE = 1'b1; m1_ADDR = 32'h0000_0400; m1_DAT_I = 32'h0000_CAFE;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      m0_STB = 1'($urandom); m0_WE = 1'($urandom); m0_ADDR = $urandom; m0_DAT_I = $urandom;
      #2;
      chk($sformatf("wr_mux%0d", i), {76'h0, bus_STB, bus_WE, bus_ADDR, bus_DAT_O, grant},
          {76'h0, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_CAFE, 2'b10});
      next_cycle();
    end
    bus_ACK = 1'b1;
    next_cycle();
    bus_ACK = 1'b0; m0_STB = 1'b0;
    #2;
    chk("wr_ack", {141'h0, m1_ACK, m1_ERR, m0_ACK}, {141'h0, 1'b1, 1'b0, 1'b0});
    m1_STB = 1'b0;
    next_cycle();

    // Timeout: slave never acknowledges
    do_reset();
    m0_STB = 1'b1;
    next_cycle();
    for (int i = 0; i < TMO - 1; i++) next_cycle();
    #2;
    chk("tmo_before", {142'h0, m0_ACK, bus_STB}, {142'h0, 1'b0, 1'b1});
    next_cycle();
    #2;
    chk("tmo_complete", {101'h0, m0_ACK, m0_ERR, m0_DAT_O, timeout_cnt, bus_STB},
        {101'h0, 1'b1, 1'b1, ERR_VAL, 8'd1, 1'b0});
    m0_STB = 1'b0;
    next_cycle();

    // ACK in the same cycle the timer would expire
    m0_STB = 1'b1;
    next_cycle();
    for (int i = 0; i < TMO - 1; i++) next_cycle();
    bus_ACK = 1'b1; bus_DAT_I = 32'h0000_55AA;
    next_cycle();
    bus_ACK = 1'b0;
    #2;
    chk("ack_at_expire", {102'h0, m0_ACK, m0_ERR, m0_DAT_O, timeout_cnt},
        {102'h0, 1'b1, 1'b0, 32'h0000_55AA, 8'd1});
    m0_STB = 1'b0;
    next_cycle();

    // Reset pulse mid-BUSY, then a fresh m1 request
    m0_STB = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; m0_STB = 1'b0; m1_STB = 1'b1;
    #2;
    chk("rst_busy", {133'h0, bus_STB, grant, m0_ACK, m1_ACK, timeout_cnt},
        {133'h0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0});
    next_cycle();
    #2;
    chk("rst_regrant", {141'h0, bus_STB, grant}, {141'h0, 1'b1, 2'b10});
    bus_ACK = 1'b1;
    next_cycle();
    bus_ACK = 1'b0;
    #2;
    chk("rst_m1_ack", {142'h0, m1_ACK, m0_ACK}, {142'h0, 1'b1, 1'b0});
    m1_STB = 1'b0;
    next_cycle();

    // Randomised traffic against the reference model
    do_reset();
    model_reset();
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we_r[m] = 1'b0; ad[m] = '0; dt[m] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[m] = 1'b1; we_r[m] = 1'($urandom); ad[m] = $urandom; dt[m] = $urandom;
          end
        end else if (md_hold && md_who == m) begin
          if ($urandom_range(0, 1) == 0) req[m] = 1'b0;
        end else if ($urandom_range(0, 59) == 0) begin
          req[m] = 1'b0;
        end
      end
      m0_STB = req[0]; m0_WE = we_r[0]; m0_ADDR = ad[0]; m0_DAT_I = dt[0];
      m1_STB = req[1]; m1_WE = we_r[1]; m1_ADDR = ad[1]; m1_DAT_I = dt[1];
      bus_ACK   = ($urandom_range(0, 7) == 0);
      bus_DAT_I = $urandom;
      #2;
      exp_v = model_expect();
      chk($sformatf("random_cyc%0d", cyc), snap(), exp_v);
      model_step();
      next_cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master arbiter in front of the WB_intercon master port. Shares the single Wishbone slave fabric (RAM, disk, VRAM, keyboard, counter) between the CPU (master 0) and a second bus master such as a disk/DMA engine (master 1).
- Sequences each transaction as grant → forward → capture ACK → release, using round-robin fairness.
- A per-transaction timeout replaces the manual ACK-override switch: if a slave never acknowledges, the block returns an error ACK instead of hanging the CPU.

Parameters:
- TIMEOUT_CYCLES, 1024: clk cycles in BUSY before a forced error completion; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timeout completion.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_STB  in  1  master 0 request
- m0_WE  in  1  master 0 write enable
- m0_ADDR  in  32  master 0 address
- m0_DAT_I  in  32  master 0 write data
- m0_DAT_O  out  32  read data to master 0
- m0_ACK  out  1  completion to master 0
- m0_ERR  out  1  timeout completion flag to master 0 (valid with m0_ACK)
- m1_STB, m1_WE, m1_ADDR, m1_DAT_I, m1_DAT_O, m1_ACK, m1_ERR: same widths and meanings, for master 1
- bus_STB  out  1  to intercon master_STB
- bus_WE  out  1  to intercon master_WE
- bus_ADDR  out  32  to intercon master_ADDR
- bus_DAT_O  out  32  to intercon master_DAT_I
- bus_DAT_I  in  32  from intercon master_DAT_O
- bus_ACK  in  1  from intercon master_ACK
- grant  out  2  one-hot current owner; 0 when idle
- timeout_cnt  out  8  saturating count of timeout events

Behaviour:
- States: IDLE, BUSY, RELEASE. Registers: owner (1 bit), last_grant (1 bit), cap_data (32), cap_err (1), tmr (counter), timeout_cnt.
- Reset, applied on the clk edge while rst=1:
  - state=IDLE, owner=0, last_grant=1 (so master 0 wins the first tie), cap_data=0, cap_err=0, tmr=0, timeout_cnt=0.
  - All outputs 0: bus_STB, m*_ACK, m*_ERR, m*_DAT_O, grant.
- IDLE:
  - bus_STB=0, grant=0.
  - If exactly one mX_STB=1: owner←X, go to BUSY.
  - If both are high: owner←~last_grant, go to BUSY.
  - tmr←0.
- BUSY:
  - bus_STB=1. bus_WE, bus_ADDR and bus_DAT_O are muxed combinationally from the owner's inputs. grant=one-hot(owner). tmr increments each cycle.
  - On bus_ACK=1: cap_data←bus_DAT_I, cap_err←0, last_grant←owner, go to RELEASE.
  - On tmr==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES≠0 and bus_ACK=0: cap_data←ERR_DATA, cap_err←1, timeout_cnt←sat+1 (holds at 255), last_grant←owner, go to RELEASE.
  - bus_ACK takes precedence over timeout in the same cycle.
  - If the owner drops STB before any ACK (abort): go to IDLE. last_grant is unchanged and no ACK is issued.
- RELEASE:
  - bus_STB=0. Owner's ACK=1, DAT_O=cap_data, ERR=cap_err; grant stays on owner.
  - Stays until the owner's STB=0, then goes to IDLE.
  - This protects masters on slower clocks (the CPU runs from a divided clock) from re-issuing a duplicate access.
- Non-owner ACK/ERR are always 0. Non-owner DAT_O=0. m*_DAT_O=0 outside RELEASE.
- Latency:
  - Request seen in IDLE → bus_STB on the next cycle.
  - Slave ACK in cycle N → master ACK from cycle N+1.
  - Minimum turnaround is 3 cycles per transaction plus slave latency.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1. A sole requester may be granted back to back.
- No combinational path from bus_ACK to m*_ACK.
- Reset mid-BUSY: bus_STB is low from the next edge and no ACK is issued. The master must re-request.

Decomposition:
- Package wb_arb_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RELEASE=2'd2
  - ERR_DATA default
  - the MASTER_CPU=0 and MASTER_DMA=1 indices
- One sub-module, wb_arb_timer: loadable counter with clear/enable, compare against TIMEOUT_CYCLES, and a one-cycle expire pulse.

Test Plan:
- m0 read; slave ACKs 2 cycles after bus_STB with bus_DAT_I=32'h1234_5678 → m0_ACK=1, m0_DAT_O=32'h1234_5678, m0_ERR=0. These hold until m0_STB drops; bus_STB=0 during RELEASE; no second bus_STB before m0_STB falls.
- m0 and m1 raise STB in the same cycle straight after reset → master 0 granted first (grant=2'b01). Next tie → grant=2'b10. Four continuous ties → order 0,1,0,1.
- m1 write, ADDR=32'h0000_0400, DAT=32'hCAFE → bus_ADDR, bus_WE=1 and bus_DAT_O match exactly while grant=2'b10; m0 inputs toggling have no effect on bus outputs.
- TIMEOUT_CYCLES=16, slave never ACKs → m0_ACK=1 and m0_ERR=1 exactly 16 cycles after bus_STB rises, m0_DAT_O=32'hDEAD_BEEF, timeout_cnt=1.
- bus_ACK arrives in the same cycle the timer expires → normal completion with ERR=0 and timeout_cnt unchanged.
- rst pulsed for 1 cycle mid-BUSY → next cycle bus_STB=0, grant=0, no ACK; the following request from m1 is granted normally.
